// File: rtl/stream_frame_checker.sv
// stream_frame_checker
// Passive AXI-Stream video frame monitor. It generates its own s_tready
// (always-ready, PRBS-random or ready-after-valid), tracks the expected
// (x, y) position of each accepted beat, and records framing errors:
//   [0] missing SOF   [1] unexpected SOF   [2] missing EOL
//   [3] unexpected EOL [4] idle timeout    [5] valid withdrawn while stalled
// Flags are sticky until err_clear; err_cnt counts every event (saturating).
// Optional feature: define STREAM_CHECK_TIMEOUT_EN to build the idle-valid
// watchdog that drives flag [4]; without it flag [4] stays 0.

module stream_frame_checker #(
   parameter int unsigned X_SIZE     = 480,
   parameter int unsigned Y_SIZE     = 480,
   parameter int unsigned READY_MODE = 2,
   parameter logic [32:0] RND_SEED   = 33'd1246504138,
   parameter int unsigned TIMEOUT    = 1000
) (
   input  logic        out_stream_aclk,
   input  logic        axi_resetn,
   input  logic        s_tvalid,
   input  logic        s_tuser,
   input  logic        s_tlast,
   output logic        s_tready,
   input  logic        err_clear,
   output logic [15:0] x_pos,
   output logic [15:0] y_pos,
   output logic [15:0] frame_cnt,
   output logic [5:0]  err_flags,
   output logic [15:0] err_cnt
);

   localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
   localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic        ready_q, ready_d;
   logic [32:0] prbs_q, prbs_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [15:0] frame_q, frame_d;
   logic [5:0]  flags_q, flags_d;
   logic [15:0] cnt_q, cnt_d;
   logic        stall_q, stall_d;

   logic        hs;
   logic [5:0]  ev;
   logic        to_ev;
   logic [2:0]  n_ev;

   assign hs = s_tvalid & ready_q;

   // Position increment that sticks at the top instead of wrapping, so an
   // overlong line stays visibly out of range.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Line advance with wrap at the last line of the frame.
   function automatic logic [15:0] line_next(input logic [15:0] v);
      return (v >= Y_LAST) ? 16'd0 : v + 16'd1;
   endfunction

   // ------------------------------------------------------------------
   // Ready generation: the PRBS always runs so that its sequence depends
   // only on time since reset, never on traffic or err_clear.
   // ------------------------------------------------------------------
   always_comb begin
      prbs_d = {prbs_q[31:0], prbs_q[32] ^ ~prbs_q[19]};
      case (READY_MODE)
         1:       ready_d = 1'b1;
         3:       ready_d = s_tvalid & ~ready_q;
         default: ready_d = prbs_q[32];
      endcase
   end

   // ------------------------------------------------------------------
   // Idle-valid watchdog
   // ------------------------------------------------------------------
`ifdef STREAM_CHECK_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;

   // Count consecutive cycles without valid; fire and restart at the limit.
   always_comb begin
      wd_d  = wd_q;
      to_ev = 1'b0;
      if (s_tvalid) begin
         wd_d = '0;
      end else if (wd_q >= 32'(TIMEOUT - 1)) begin
         wd_d  = '0;
         to_ev = 1'b1;
      end else begin
         wd_d = wd_q + 32'd1;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
      if (!axi_resetn) wd_q <= '0;
      else             wd_q <= wd_d;
   end
`else
   assign to_ev = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Position tracking and framing checks on each handshake.
   // An unexpected SOF resynchronises to (0,0) first, so the EOL check of
   // the same beat is evaluated against the restarted line.
   // ------------------------------------------------------------------
   always_comb begin
      logic [15:0] xs;
      logic [15:0] ys;
      x_d     = x_q;
      y_d     = y_q;
      frame_d = frame_q;
      ev      = '0;
      xs      = x_q;
      ys      = y_q;
      if (hs) begin
         if (x_q == 16'd0 && y_q == 16'd0) begin
            if (s_tuser) frame_d = frame_q + 16'd1;
            else         ev[0]   = 1'b1;
         end else if (s_tuser) begin
            ev[1]   = 1'b1;
            frame_d = frame_q + 16'd1;
            xs      = '0;
            ys      = '0;
         end
         y_d = ys;
         if (xs == X_LAST) begin
            if (s_tlast) begin
               x_d = '0;
               y_d = line_next(ys);
            end else begin
               ev[2] = 1'b1;
               x_d   = sat_inc(xs);
            end
         end else if (s_tlast) begin
            ev[3] = 1'b1;
            x_d   = '0;
            y_d   = line_next(ys);
         end else begin
            x_d = sat_inc(xs);
         end
      end
      // A beat offered while stalled must stay valid in the next cycle.
      ev[4] = to_ev;
      ev[5] = stall_q & ~s_tvalid;
   end

   // ------------------------------------------------------------------
   // Error bookkeeping: clear first, then record this cycle's events so a
   // simultaneous event is never lost.
   // ------------------------------------------------------------------
   always_comb begin
      logic [15:0] base;
      logic [16:0] sum;
      n_ev = '0;
      for (int i = 0; i < 6; i++) n_ev = n_ev + 3'(ev[i]);
      base    = err_clear ? 16'd0 : cnt_q;
      sum     = {1'b0, base} + 17'(n_ev);
      cnt_d   = sum[16] ? 16'hFFFF : sum[15:0];
      flags_d = (err_clear ? 6'd0 : flags_q) | ev;
      stall_d = s_tvalid & ~ready_q;
   end

   // State registers; reset discards any partial line.
   always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         ready_q <= 1'b0;
         prbs_q  <= RND_SEED;
         x_q     <= '0;
         y_q     <= '0;
         frame_q <= '0;
         flags_q <= '0;
         cnt_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
         prbs_q  <= prbs_d;
         x_q     <= x_d;
         y_q     <= y_d;
         frame_q <= frame_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign s_tready  = ready_q;
   assign x_pos     = x_q;
   assign y_pos     = y_q;
   assign frame_cnt = frame_q;
   assign err_flags = flags_q;
   assign err_cnt   = cnt_q;

endmodule

// File: doc/stream_frame_checker.md
STREAM_FRAME_CHECKER -- requirements
Module: stream_frame_checker

Interface
REQ-001 Parameter X_SIZE, default 480: words per line.
REQ-002 Parameter Y_SIZE, default 480: lines per frame.
REQ-003 Parameter READY_MODE, default 2: 1 always-ready, 2 PRBS-random, 3 ready-after-valid.
REQ-004 Parameter RND_SEED, default 1246504138: 33-bit PRBS seed.
REQ-005 Parameter TIMEOUT, default 1000: idle-valid watchdog limit in cycles.
REQ-006 Port out_stream_aclk, in, 1: the single clock; all logic rises on it.
REQ-007 Port axi_resetn, in, 1: asynchronous active-low reset.
REQ-008 Port s_tvalid / s_tuser / s_tlast, in, 1 each: monitored AXI-Stream valid, SOF, EOL.
REQ-009 Port s_tready, out, 1: generated ready, registered.
REQ-010 Port err_clear, in, 1: synchronous clear of error state and counters.
REQ-011 Port x_pos, out, 16: expected word index; y_pos, out, 16: expected line index.
REQ-012 Port frame_cnt, out, 16: frames started, wraps at 2^16.
REQ-013 Port err_flags, out, 6: sticky bits [0] missing SOF, [1] unexpected SOF, [2] missing EOL, [3] unexpected EOL, [4] timeout, [5] valid dropped.
REQ-014 Port err_cnt, out, 16: total error events, saturating at 16'hFFFF.

Function
REQ-015 Handshake hs = s_tvalid & s_tready; position logic advances only on hs.
REQ-016 Mode 1: s_tready = 1 every cycle after reset.
REQ-017 Mode 2: each cycle prbs <= {prbs[31:0], prbs[32] ^ ~prbs[19]}; s_tready <= prbs[32].
REQ-018 Mode 3: s_tready <= s_tvalid & ~s_tready (one-cycle ready pulse after each valid, then low).
REQ-019 SOF at hs, position (0,0): s_tuser=1 -> frame_cnt+1; s_tuser=0 -> flag[0].
REQ-020 SOF at hs, other position: s_tuser=1 -> flag[1], frame_cnt+1, resync to (0,0) before EOL evaluation.
REQ-021 EOL at hs, x_pos==X_SIZE-1: s_tlast=1 -> x_pos=0, y_pos+1; s_tlast=0 -> flag[2], x_pos+1 (saturating at 16'hFFFF).
REQ-022 EOL at hs, x_pos<>X_SIZE-1: s_tlast=1 -> flag[3], x_pos=0, y_pos+1; else x_pos+1.
REQ-023 y_pos wraps from Y_SIZE-1 to 0 on line end.
REQ-024 Valid-drop: s_tvalid high and s_tready low in cycle n, s_tvalid low in cycle n+1 -> flag[5].
REQ-025 Each error event sets its flag and adds 1 to err_cnt one cycle after the detecting edge; several events in one cycle add their count.
REQ-026 err_clear: flags and err_cnt cleared; an event in the same cycle is recorded after the clear (flag=1, err_cnt=count of that cycle's events).
REQ-027 err_clear does not affect x_pos, y_pos, frame_cnt or the PRBS.

Reset
REQ-028 axi_resetn low, asynchronously: s_tready=0, x_pos=0, y_pos=0, frame_cnt=0, err_flags=0, err_cnt=0, prbs=RND_SEED, watchdog=0.
REQ-029 Reset mid-line discards position; first hs after release is checked as (0,0).

Configuration
REQ-030 Macro STREAM_CHECK_TIMEOUT_EN defined: watchdog counts cycles with s_tvalid low, clears on s_tvalid high; on reaching TIMEOUT it raises flag[4], err_cnt+1, and restarts from 0.
REQ-031 Macro undefined: no watchdog logic; flag[4] tied 0.

Verification
REQ-032 READY_MODE=1, clean 480x480 frame with SOF at (0,0), EOL each line -> frame_cnt=1, err_flags=0, x_pos=0, y_pos=0 at end.
REQ-033 Drop s_tlast on line 3 word 479 -> flag[2]=1, err_cnt=1, x_pos=480 after that beat.
REQ-034 s_tuser on word 10 of line 5 -> flag[1]=1, frame_cnt+1, x_pos=1, y_pos=0 after beat.
REQ-035 READY_MODE=3, constant s_tvalid=1 -> s_tready toggles 0,1,0,1; exactly one hs per 2 cycles, no flag[5].
REQ-036 STREAM_CHECK_TIMEOUT_EN, TIMEOUT=1000, s_tvalid low 2500 cycles -> flag[4]=1, err_cnt=2.
REQ-037 Assert axi_resetn low at x_pos=200 -> all outputs zero immediately; next frame without errors.
